// File: rtl/inst_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_pkg
// Shared definitions for the fetch stage and the decoder.
//   PC_W      : default program-counter / instruction-address width
//   BS_*      : branch-select codes driven by the decoder
//   state_t   : fetch-stage sequencer states
// ---------------------------------------------------------------------------
package inst_fetch_unit_pkg;

   localparam int PC_W = 16;

   localparam logic [2:0] BS_INC = 3'b000;
   localparam logic [2:0] BS_SKZ = 3'b001;
   localparam logic [2:0] BS_JMP = 3'b010;
   localparam logic [2:0] BS_RET = 3'b011;
   localparam logic [2:0] BS_JSR = 3'b100;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_INTR  = 2'b10
   } state_t;

endpackage

// File: rtl/inst_fetch_unit_next_pc_sel.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit_next_pc_sel
// Combinational next-PC multiplexer for a completing instruction.
//   pc          in  current PC
//   bs          in  branch select from the decoder
//   zero_flag   in  ALU zero flag (used by skip-on-zero)
//   jump_target in  JMP/JSR target
//   ret_addr    in  popped return address for RET
//   npc         out next PC (mod 2^PC_W)
// ---------------------------------------------------------------------------
module inst_fetch_unit_next_pc_sel #(
   parameter int PC_W = inst_fetch_unit_pkg::PC_W
) (
   input  logic [PC_W-1:0] pc,
   input  logic [2:0]      bs,
   input  logic            zero_flag,
   input  logic [PC_W-1:0] jump_target,
   input  logic [PC_W-1:0] ret_addr,
   output logic [PC_W-1:0] npc
);
   import inst_fetch_unit_pkg::*;

   logic [PC_W-1:0] w_pc_inc1;
   logic [PC_W-1:0] w_pc_inc2;

   // Sequential successors; the adders wrap naturally at 2^PC_W.
   assign w_pc_inc1 = pc + PC_W'(1);
   assign w_pc_inc2 = pc + PC_W'(2);

   // Select the next PC from the branch-select code; unused codes fall through.
   always_comb begin
      npc = w_pc_inc1;
      case (bs)
         BS_INC: npc = w_pc_inc1;
         BS_SKZ: begin
            if (zero_flag) begin
               npc = w_pc_inc2;
            end else begin
               npc = w_pc_inc1;
            end
         end
         BS_JMP: npc = jump_target;
         BS_RET: npc = ret_addr;
         BS_JSR: npc = jump_target;
         default: npc = w_pc_inc1;
      endcase
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
// Fetch stage: owns PC and IR, fetches over a valid handshake, executes one
// instruction per EXEC slot, applies branch selects and injects interrupts.
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr/imem_rd instruction memory address (== PC) and read request
//   imem_data/valid   instruction word and its valid strobe
//   inst/inst_valid   IR to the decoder, high while executing
//   stall             holds the current EXEC slot
//   bs, zero_flag     branch select and ALU zero flag
//   jump_target       JMP/JSR target; ret_addr popped RET address
//   ion/iof           set/clear interrupt-enable pulses (iof wins)
//   irq               level interrupt request
//   ien               one-cycle interrupt indicator to the decoder
//   ret_pc            return address to push; int_en current enable flag
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter int                                 PC_W      = inst_fetch_unit_pkg::PC_W,
   parameter int                                 INST_W    = 16,
   parameter logic [inst_fetch_unit_pkg::PC_W-1:0] RESET_VEC = 16'h0000,
   parameter logic [inst_fetch_unit_pkg::PC_W-1:0] INT_VEC   = 16'h0010
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [PC_W-1:0]   imem_addr,
   output logic              imem_rd,
   input  logic [INST_W-1:0] imem_data,
   input  logic              imem_valid,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   input  logic              stall,
   input  logic [2:0]        bs,
   input  logic              zero_flag,
   input  logic [PC_W-1:0]   jump_target,
   input  logic [PC_W-1:0]   ret_addr,
   input  logic              ion,
   input  logic              iof,
   input  logic              irq,
   output logic              ien,
   output logic [PC_W-1:0]   ret_pc,
   output logic              int_en
);
   import inst_fetch_unit_pkg::*;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   r_ret_pc;
   logic [INST_W-1:0] r_ir;
   logic              r_int_en;
   logic              w_int_en_nxt;
   logic              w_exec_done;
   logic              w_take_int;
   logic [PC_W-1:0]   w_npc;

   inst_fetch_unit_next_pc_sel #(
      .PC_W (PC_W)
   ) u_next_pc_sel (
      .pc          (r_pc),
      .bs          (bs),
      .zero_flag   (zero_flag),
      .jump_target (jump_target),
      .ret_addr    (ret_addr),
      .npc         (w_npc)
   );

   // Sequencer next state; an instruction completes on the first unstalled EXEC cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_exec_done = 1'b0;
      w_take_int  = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (imem_valid) begin
               w_state_nxt = ST_EXEC;
            end else begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (stall) begin
               w_state_nxt = ST_EXEC;
            end else begin
               w_exec_done = 1'b1;
               // The enable seen here is the registered one, so ion/iof take effect next completion.
               if (irq && r_int_en) begin
                  w_take_int  = 1'b1;
                  w_state_nxt = ST_INTR;
               end else begin
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         ST_INTR: w_state_nxt = ST_FETCH;
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   // Interrupt-enable update: entry clears it, then iof, then ion.
   always_comb begin
      w_int_en_nxt = r_int_en;
      if (w_take_int) begin
         w_int_en_nxt = 1'b0;
      end else if (iof) begin
         w_int_en_nxt = 1'b0;
      end else if (ion) begin
         w_int_en_nxt = 1'b1;
      end else begin
         w_int_en_nxt = r_int_en;
      end
   end

   // State, PC, IR, return-PC and enable registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= RESET_VEC;
         r_ir     <= '0;
         r_ret_pc <= '0;
         r_int_en <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_int_en <= w_int_en_nxt;
         if ((r_state == ST_FETCH) && imem_valid) begin
            r_ir <= imem_data;
         end
         if (w_exec_done) begin
            if (w_take_int) begin
               // The interrupted flow resumes at the PC it would have gone to.
               r_pc     <= INT_VEC;
               r_ret_pc <= w_npc;
            end else begin
               r_pc <= w_npc;
               if (bs == BS_JSR) begin
                  r_ret_pc <= r_pc + PC_W'(1);
               end
            end
         end
      end
   end

   assign imem_addr  = r_pc;
   // The reset state is FETCH, so the read request is gated off while reset is held.
   assign imem_rd    = (r_state == ST_FETCH) && rst_n;
   assign inst       = r_ir;
   assign inst_valid = (r_state == ST_EXEC);
   assign ien        = (r_state == ST_INTR);
   assign ret_pc     = r_ret_pc;
   assign int_en     = r_int_en;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder. Holds the program counter (PC) and the instruction register (IR).
- Reads instruction memory through a valid handshake and presents one instruction per execute slot to the decoder.
- Applies the decoder's branch-select (bs) code to compute the next PC, and injects interrupt cycles by driving ien to the decoder.
- Presents the return PC to the hardware stack for JSR and interrupt pushes.

Parameters:
- PC_W, 16, PC and memory address width.
- INST_W, 16, instruction width.
- RESET_VEC, 16'h0000, PC value after reset.
- INT_VEC, 16'h0010, PC loaded when an interrupt is taken.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  PC_W  instruction memory address; always equals PC.
- imem_rd  out  1  read request; high throughout FETCH.
- imem_data  in  INST_W  instruction word from memory.
- imem_valid  in  1  imem_data valid this cycle.
- inst  out  INST_W  IR contents, routed to the decoder Inst input.
- inst_valid  out  1  high in EXEC; IR is stable and executing.
- stall  in  1  holds EXEC (for example, a data-memory wait).
- bs  in  3  branch select from the decoder.
- zero_flag  in  1  ALU zero flag.
- jump_target  in  PC_W  target address for JMP/JSR.
- ret_addr  in  PC_W  popped return address for RET.
- ion  in  1  pulse; sets the interrupt-enable flag.
- iof  in  1  pulse; clears the interrupt-enable flag.
- irq  in  1  level interrupt request.
- ien  out  1  interrupt cycle indicator to the decoder.
- ret_pc  out  PC_W  return address to push.
- int_en  out  1  current interrupt-enable flag.

Behaviour:
- Reset (asynchronous, immediate): PC=RESET_VEC, IR=0, state=FETCH, int_en=0, ret_pc=0. Outputs go to inst_valid=0, ien=0, imem_rd=0 while rst_n is low.
- Reset asserted mid-fetch or mid-exec aborts the operation with no PC update. The first cycle after release is FETCH at RESET_VEC.
- States: FETCH, EXEC, INTR.
- FETCH:
  - imem_rd=1 and imem_addr=PC.
  - Waits any number of cycles for imem_valid.
  - On imem_valid: IR<=imem_data and go to EXEC.
  - imem_valid outside FETCH is ignored.
- EXEC:
  - inst_valid=1 every cycle of EXEC.
  - If stall=1: hold state, PC and IR; bs is ignored.
  - Otherwise compute next PC (npc). Arithmetic is mod 2^PC_W; FFFF+1 wraps to 0000.
    - bs=000: npc=PC+1.
    - bs=001 (skip on zero): npc = zero_flag ? PC+2 : PC+1.
    - bs=010 (jump): npc=jump_target.
    - bs=011 (return): npc=ret_addr.
    - bs=100 (JSR): npc=jump_target; ret_pc<=PC+1 in the same edge.
    - Other codes: npc=PC+1.
  - Interrupt check on the same edge: if irq && int_en, then ret_pc<=npc, PC<=INT_VEC, int_en<=0, and go to INTR. Otherwise PC<=npc and go to FETCH.
- INTR: exactly one cycle with ien=1 and inst_valid=0; the decoder pushes ret_pc. Then go to FETCH at INT_VEC.
- Fetch-to-execute latency: minimum 2 cycles per instruction with zero-wait memory (1 FETCH + 1 EXEC). An interrupt adds 1 cycle.
- ion/iof:
  - Sampled in every state.
  - ion and iof high together: iof wins.
  - Interrupt entry clears int_en, and this overrides an ion on the same edge.
  - A change in int_en takes effect at the next EXEC completion.
- ret_pc holds its value until the next JSR or interrupt.
- imem_rd is deasserted in EXEC and INTR.

Decomposition:
- Shared package:
  - BS_* localparams: BS_INC=3'b000, BS_SKZ=3'b001, BS_JMP=3'b010, BS_RET=3'b011, BS_JSR=3'b100. The decoder uses the same constants.
  - State encoding: ST_FETCH, ST_EXEC, ST_INTR.
  - PC_W.
- One natural sub-module: next_pc_sel, a combinational npc mux over bs, zero_flag, jump_target and ret_addr. The FSM, PC, IR and int_en registers stay in the top.

Test Plan:
- Reset, then zero-wait memory with imem_data=16'h7100 and bs=000 → imem_addr sequence 0000, 0001, 0002; inst_valid high every 2nd cycle; inst=7100.
- imem_valid delayed 3 cycles at PC=0005 → imem_rd high for 4 cycles, inst_valid stays low, then IR loads and PC becomes 0006 after EXEC.
- EXEC at PC=0010 with bs=001:
  - zero_flag=1 → next fetch address 0012.
  - zero_flag=0 → next fetch address 0011.
  - PC=FFFF, bs=000 → next fetch address 0000.
- JSR at PC=0020 with jump_target=0100, bs=100 → ret_pc=0021, next fetch 0100. Later RET with ret_addr=0021, bs=011 → next fetch 0021.
- ion pulse, then irq=1 during EXEC at PC=0030 with bs=000 → ret_pc=0031, one INTR cycle with ien=1, int_en=0, next fetch 0010. irq still high in the following EXEC → no second interrupt.
- stall=1 for 3 cycles in EXEC → PC, IR and inst_valid held. rst_n low mid-stall → inst_valid=0 immediately; after release, fetch 0000 with int_en=0.
